// File: rtl/imem_port_arbiter.sv
// ---------------------------------------------------------------------------
// imem_port_arbiter
//
// Purpose:
//   Shares one single-ported, word-addressed instruction memory between the
//   pipeline fetch stage (read only) and the program loader / debug port
//   (read and write). At most one access is granted per cycle. Read data
//   comes back one cycle after the grant, on the port that was granted.
//   Fetch has priority by default. The loader can lock the memory for
//   back-to-back burst accesses.
//
// Optional feature (compile-time macro IMEM_ARB_STARVE_EN):
//   When defined, an 8-bit saturating starvation counter counts the cycles
//   in which the loader requests but is not granted. Once it reaches
//   STARVE_MAX, the loader wins over fetch in FETCH_PRI. When undefined, the
//   counter is not built and FETCH_PRI is strict fetch priority.
//
// Parameters:
//   DEPTH       memory depth in words (power of two)
//   WIDTH       data width
//   STARVE_MAX  denied loader cycles before a forced loader grant (1..255)
//
// Ports:
//   clk, reset             rising-edge clock, synchronous active-high reset
//   f_req, f_addr          fetch read request and byte address
//   f_gnt                  fetch accepted this cycle (combinational)
//   f_rvalid, f_rdata      fetch read response, one cycle after f_gnt
//   l_req, l_we, l_lock    loader request, write select, lock request
//   l_addr, l_wdata        loader byte address and write data
//   l_gnt                  loader accepted this cycle (combinational)
//   l_rvalid, l_rdata      loader read response, one cycle after a read grant
//   mem_en, mem_we         memory access strobe and write enable
//   mem_addr, mem_wdata    memory word index and write data
//   mem_rdata              registered memory read data (cycle after mem_en)
// ---------------------------------------------------------------------------
module imem_port_arbiter #(
  parameter int DEPTH      = 1024,
  parameter int WIDTH      = 32,
  parameter int STARVE_MAX = 8
) (
  input  logic                     clk,
  input  logic                     reset,

  input  logic                     f_req,
  input  logic [31:0]              f_addr,
  output logic                     f_gnt,
  output logic                     f_rvalid,
  output logic [WIDTH-1:0]         f_rdata,

  input  logic                     l_req,
  input  logic                     l_we,
  input  logic                     l_lock,
  input  logic [31:0]              l_addr,
  input  logic [WIDTH-1:0]         l_wdata,
  output logic                     l_gnt,
  output logic                     l_rvalid,
  output logic [WIDTH-1:0]         l_rdata,

  output logic                     mem_en,
  output logic                     mem_we,
  output logic [$clog2(DEPTH)-1:0] mem_addr,
  output logic [WIDTH-1:0]         mem_wdata,
  input  logic [WIDTH-1:0]         mem_rdata
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic {
    FETCH_PRI = 1'b0,
    LOAD_LOCK = 1'b1
  } state_t;

  typedef enum logic [1:0] {
    OWN_NONE  = 2'd0,
    OWN_FETCH = 2'd1,
    OWN_LOAD  = 2'd2
  } owner_t;

  state_t        state_q, state_d;
  owner_t        owner_q, owner_d;
  logic [AW-1:0] f_idx;
  logic [AW-1:0] l_idx;
  logic          starve_force;

  // Word index: drop the byte offset and everything above the memory size,
  // so out-of-range addresses wrap modulo DEPTH.
  assign f_idx = f_addr[AW+1:2];
  assign l_idx = l_addr[AW+1:2];

  // The dropped address bits are intentionally ignored.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{f_addr[31:AW+2], f_addr[1:0],
                              l_addr[31:AW+2], l_addr[1:0]};

`ifdef IMEM_ARB_STARVE_EN
  logic [7:0] starve_cnt_q, starve_cnt_d;

  assign starve_force = (starve_cnt_q >= 8'(STARVE_MAX));

  // Saturating count of denied loader cycles; any loader grant clears it.
  always_comb begin
    starve_cnt_d = starve_cnt_q;
    if (l_gnt) begin
      starve_cnt_d = 8'd0;
    end else if (l_req && (starve_cnt_q != 8'hFF)) begin
      starve_cnt_d = starve_cnt_q + 8'd1;
    end
  end
`else
  localparam int unused_starve_max = STARVE_MAX;
  assign starve_force = 1'b0;
`endif

  // Grant selection. Outputs are forced low while reset is held so that a
  // reset cycle neither grants nor records a new access.
  always_comb begin
    f_gnt = 1'b0;
    l_gnt = 1'b0;
    if (!reset) begin
      if (state_q == LOAD_LOCK) begin
        l_gnt = l_req;
      end else if (l_req && (starve_force || !f_req)) begin
        l_gnt = 1'b1;
      end else begin
        f_gnt = f_req;
      end
    end
  end

  // Memory-side drive from whichever requester won; all zero when idle.
  always_comb begin
    mem_en    = f_gnt | l_gnt;
    mem_we    = l_gnt & l_we;
    mem_addr  = '0;
    mem_wdata = '0;
    if (l_gnt) begin
      mem_addr  = l_idx;
      mem_wdata = l_wdata;
    end else if (f_gnt) begin
      mem_addr  = f_idx;
    end
  end

  // Lock entry needs an actual loader grant with l_lock; lock exit happens on
  // any cycle where l_lock is low, independent of l_req.
  always_comb begin
    state_d = state_q;
    case (state_q)
      FETCH_PRI: if (l_gnt && l_lock) state_d = LOAD_LOCK;
      LOAD_LOCK: if (!l_lock)         state_d = FETCH_PRI;
      default:                        state_d = FETCH_PRI;
    endcase
  end

  // Owner tag of the read issued this cycle; writes leave no response.
  always_comb begin
    owner_d = OWN_NONE;
    if (f_gnt) begin
      owner_d = OWN_FETCH;
    end else if (l_gnt && !l_we) begin
      owner_d = OWN_LOAD;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= FETCH_PRI;
      owner_q      <= OWN_NONE;
`ifdef IMEM_ARB_STARVE_EN
      starve_cnt_q <= 8'd0;
`endif
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
`ifdef IMEM_ARB_STARVE_EN
      starve_cnt_q <= starve_cnt_d;
`endif
    end
  end

  // Response steering. An in-flight response is suppressed immediately when
  // reset is asserted in the response cycle, so it is never seen.
  always_comb begin
    f_rvalid = (owner_q == OWN_FETCH) && !reset;
    l_rvalid = (owner_q == OWN_LOAD)  && !reset;
    f_rdata  = f_rvalid ? mem_rdata : '0;
    l_rdata  = l_rvalid ? mem_rdata : '0;
  end

endmodule

// File: tb/tb_imem_port_arbiter.sv
// ---------------------------------------------------------------------------
// tb_imem_port_arbiter
//
// Self-checking bench for imem_port_arbiter with a registered memory model.
// Every read grant pushes the expected response (from a shadow copy of the
// memory kept by the bench) into a queue; the next cycle pops and compares.
// Directed phases: reset, fetch read, write-then-read, loader read, address
// wrap, locked burst, starvation (macro dependent), reset mid-operation and
// lock release by reset.
// ---------------------------------------------------------------------------
module tb_imem_port_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        f_req;
  logic [31:0] f_addr;
  logic        f_gnt, f_rvalid;
  logic [31:0] f_rdata;
  logic        l_req, l_we, l_lock;
  logic [31:0] l_addr, l_wdata;
  logic        l_gnt, l_rvalid;
  logic [31:0] l_rdata;
  logic        mem_en, mem_we;
  logic [9:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata = 32'h0;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    bit          src;   // 0 = fetch, 1 = loader
    logic [31:0] data;
  } exp_t;

  exp_t        sb_q[$];
  logic [31:0] shadow [0:1023];
  logic [31:0] mem_model [0:1023];
  bit          mem_init_done = 1'b0;

  imem_port_arbiter #(
    .DEPTH(1024), .WIDTH(32), .STARVE_MAX(8)
  ) dut (
    .clk(clk), .reset(reset),
    .f_req(f_req), .f_addr(f_addr), .f_gnt(f_gnt),
    .f_rvalid(f_rvalid), .f_rdata(f_rdata),
    .l_req(l_req), .l_we(l_we), .l_lock(l_lock), .l_addr(l_addr),
    .l_wdata(l_wdata), .l_gnt(l_gnt), .l_rvalid(l_rvalid), .l_rdata(l_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] init_val(input int i);
    if (i == 4) return 32'hDEADBEEF;
    return (32'(i) * 32'h9E3779B1) ^ 32'h5A5A0000;
  endfunction

  function automatic logic [9:0] idx(input logic [31:0] a);
    return a[11:2];
  endfunction

  // Single-ported memory with registered read data.
  always @(posedge clk) begin
    if (!mem_init_done) begin
      for (int i = 0; i < 1024; i++) mem_model[i] <= init_val(i);
      mem_init_done <= 1'b1;
    end else if (mem_en) begin
      if (mem_we) mem_model[mem_addr] <= mem_wdata;
      else        mem_rdata <= mem_model[mem_addr];
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got,
                          input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  // Scoreboard step, run once per cycle at the falling edge.
  task automatic sb_step();
    exp_t e;
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      $display("[%0t] rsp %s data=0x%08h", $time, e.src ? "loader" : "fetch", e.data);
      if (!e.src) begin
        check_eq("f_rvalid", 32'(f_rvalid), 32'd1);
        check_eq("f_rdata",  f_rdata, e.data);
        check_eq("l_rvalid_quiet", 32'(l_rvalid), 32'd0);
      end else begin
        check_eq("l_rvalid", 32'(l_rvalid), 32'd1);
        check_eq("l_rdata",  l_rdata, e.data);
        check_eq("f_rvalid_quiet", 32'(f_rvalid), 32'd0);
      end
    end else begin
      check_eq("f_rvalid_idle", 32'(f_rvalid), 32'd0);
      check_eq("l_rvalid_idle", 32'(l_rvalid), 32'd0);
      check_eq("f_rdata_idle",  f_rdata, 32'd0);
      check_eq("l_rdata_idle",  l_rdata, 32'd0);
    end
    check_eq("gnt_excl", 32'(f_gnt & l_gnt), 32'd0);
    if (f_gnt) begin
      check_eq("f_mem_addr", 32'(mem_addr), 32'(idx(f_addr)));
      sb_q.push_back('{src: 1'b0, data: shadow[idx(f_addr)]});
    end
    if (l_gnt) begin
      check_eq("l_mem_addr", 32'(mem_addr), 32'(idx(l_addr)));
      if (l_we) begin
        check_eq("mem_we_wr", 32'(mem_we), 32'd1);
        check_eq("mem_wdata", mem_wdata, l_wdata);
        shadow[idx(l_addr)] = l_wdata;
      end else begin
        sb_q.push_back('{src: 1'b1, data: shadow[idx(l_addr)]});
      end
    end
    if (!f_gnt && !l_gnt) begin
      check_eq("mem_en_idle",   32'(mem_en), 32'd0);
      check_eq("mem_addr_idle", 32'(mem_addr), 32'd0);
    end
  endtask

  task automatic settle();
    @(negedge clk);
    sb_step();
  endtask

  task automatic advance();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    f_req = 1'b0; f_addr = 32'h0;
    l_req = 1'b0; l_we = 1'b0; l_lock = 1'b0; l_addr = 32'h0; l_wdata = 32'h0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 1024; i++) shadow[i] = init_val(i);
    reset = 1'b1;
    idle_inputs();
    advance();

    // Reset: all outputs low.
    settle();
    check_eq("rst_f_gnt", 32'(f_gnt), 32'd0);
    check_eq("rst_l_gnt", 32'(l_gnt), 32'd0);
    advance();
    reset = 1'b0;
    settle();
    advance();

    // Fetch read of 0x10 -> word 4.
    f_req = 1'b1; f_addr = 32'h10;
    settle();
    check_eq("t1_f_gnt",    32'(f_gnt), 32'd1);
    check_eq("t1_mem_addr", 32'(mem_addr), 32'd4);
    check_eq("t1_l_gnt",    32'(l_gnt), 32'd0);
    check_eq("t1_mem_we",   32'(mem_we), 32'd0);
    advance();
    f_req = 1'b0;
    settle();
    check_eq("t1_f_rdata", f_rdata, 32'hDEADBEEF);
    check_eq("t1_l_rdata", l_rdata, 32'h0);
    advance();

    // Loader write to 0x20, then fetch read of the same word.
    l_req = 1'b1; l_we = 1'b1; l_addr = 32'h20; l_wdata = 32'h12345678;
    settle();
    check_eq("t2_l_gnt",    32'(l_gnt), 32'd1);
    check_eq("t2_mem_we",   32'(mem_we), 32'd1);
    check_eq("t2_mem_addr", 32'(mem_addr), 32'd8);
    advance();
    idle_inputs();
    f_req = 1'b1; f_addr = 32'h20;
    settle();
    check_eq("t2_f_gnt", 32'(f_gnt), 32'd1);
    check_eq("t2_wr_no_rvalid", 32'(l_rvalid), 32'd0);
    advance();
    f_req = 1'b0;
    settle();
    check_eq("t2_f_rdata", f_rdata, 32'h12345678);
    advance();

    // Loader read of 0x20.
    l_req = 1'b1; l_we = 1'b0; l_addr = 32'h20;
    settle();
    check_eq("t3_l_gnt", 32'(l_gnt), 32'd1);
    advance();
    l_req = 1'b0;
    settle();
    check_eq("t3_l_rdata", l_rdata, 32'h12345678);
    advance();

    // Address wrap: 0x1004 -> word 1.
    f_req = 1'b1; f_addr = 32'h1004;
    settle();
    check_eq("t4_wrap_addr", 32'(mem_addr), 32'd1);
    advance();
    f_req = 1'b0;
    settle();
    advance();

    // Locked 4-beat write burst; fetch requests from the second beat on.
    l_req = 1'b1; l_we = 1'b1; l_lock = 1'b1; l_addr = 32'h40; l_wdata = 32'hC0DE0000;
    settle();
    check_eq("t5_beat0_l_gnt", 32'(l_gnt), 32'd1);
    check_eq("t5_beat0_f_gnt", 32'(f_gnt), 32'd0);
    advance();
    f_req = 1'b1; f_addr = 32'h44;
    for (int b = 1; b < 4; b++) begin
      l_addr = 32'h40 + 32'(4 * b); l_wdata = 32'hC0DE0000 + 32'(b);
      settle();
      check_eq("t5_beat_l_gnt", 32'(l_gnt), 32'd1);
      check_eq("t5_beat_f_gnt", 32'(f_gnt), 32'd0);
      advance();
    end
    l_req = 1'b0; l_we = 1'b0; l_lock = 1'b0;
    settle();
    check_eq("t5_unlock_f_gnt", 32'(f_gnt), 32'd0);
    advance();
    settle();
    check_eq("t5_after_f_gnt", 32'(f_gnt), 32'd1);
    advance();
    f_req = 1'b0;
    settle();
    check_eq("t5_f_rdata", f_rdata, 32'hC0DE0001);
    advance();

    // Contention: fetch and loader both requesting continuously.
    f_req = 1'b1; l_req = 1'b1; l_we = 1'b0; l_addr = 32'h10;
`ifdef IMEM_ARB_STARVE_EN
    for (int k = 1; k <= 18; k++) begin
      f_addr = 32'h100 + 32'(4 * k);
      settle();
      check_eq("t6_l_gnt", 32'(l_gnt), 32'((k == 9) || (k == 18)));
      check_eq("t6_f_gnt", 32'(f_gnt), 32'(!((k == 9) || (k == 18))));
      advance();
    end
`else
    for (int k = 1; k <= 20; k++) begin
      f_addr = 32'h100 + 32'(4 * k);
      settle();
      check_eq("t6_l_gnt", 32'(l_gnt), 32'd0);
      check_eq("t6_f_gnt", 32'(f_gnt), 32'd1);
      advance();
    end
`endif
    idle_inputs();
    settle();
    advance();

    // Reset in the cycle after a read grant drops the response and clears
    // the starvation count.
    f_req = 1'b1; f_addr = 32'h10; l_req = 1'b1; l_addr = 32'h20;
    for (int k = 0; k < 3; k++) begin
      settle();
      advance();
    end
    reset = 1'b1;
    sb_q.delete();
    settle();
    check_eq("t7_rst_f_rvalid", 32'(f_rvalid), 32'd0);
    check_eq("t7_rst_mem_en",   32'(mem_en), 32'd0);
    advance();
    reset = 1'b0;
    for (int k = 1; k <= 9; k++) begin
      settle();
`ifdef IMEM_ARB_STARVE_EN
      check_eq("t7_l_gnt", 32'(l_gnt), 32'(k == 9));
`else
      check_eq("t7_l_gnt", 32'(l_gnt), 32'd0);
`endif
      advance();
    end
    idle_inputs();
    settle();
    advance();

    // Reset releases a held lock.
    l_req = 1'b1; l_we = 1'b1; l_lock = 1'b1; l_addr = 32'h80; l_wdata = 32'hABCD0000;
    settle();
    check_eq("t8_l_gnt", 32'(l_gnt), 32'd1);
    advance();
    l_req = 1'b0; reset = 1'b1;
    settle();
    advance();
    reset = 1'b0;
    f_req = 1'b1; f_addr = 32'h80;
    settle();
    check_eq("t8_f_gnt_after_rst", 32'(f_gnt), 32'd1);
    advance();
    idle_inputs();
    settle();
    check_eq("t8_f_rdata", f_rdata, 32'hABCD0000);
    advance();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
